// File: rtl/pusch_scr_core.sv
// PUSCH bit scrambler: sequences the Gold generator, XORs data bits and resolves x/y UCI tags.
// Optional build macro PUSCH_SCR_BYPASS_EN adds a per-codeword bypass input (no generator activity).
module pusch_scr_core #(
  parameter int unsigned LEN_W = 17
) (
  input  logic             CLK_PR_new,
  input  logic             RST_PR,
  input  logic             start,
  input  logic [LEN_W-1:0] cw_len,
`ifdef PUSCH_SCR_BYPASS_EN
  input  logic             bypass,
`endif
  input  logic             gold_valid,
  input  logic             gold_bit,
  output logic             gen_shift,
  output logic             gen_out_en,
  output logic             gen_adv,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [1:0]       in_tag,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] TAG_X = 2'b01;
  localparam logic [1:0] TAG_Y = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WARM  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             prev_q;
  logic             out_valid_q;
  logic             out_bit_q;
  logic             gen_shift_q;
  logic             gen_out_en_q;
  logic             busy_q;
  logic             done_q;
  logic             byp_q;
  logic             accept_c;
  logic             scr_bit_c;
  logic             last_c;

`ifndef PUSCH_SCR_BYPASS_EN
  assign byp_q = 1'b0;
`endif

  // Handshake: the output register may reload on the same cycle it is drained.
  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept_c  = in_valid && in_ready;
  assign gen_adv   = accept_c && !byp_q;
  assign last_c    = (cnt_q == (len_q - LEN_W'(1)));

  // UCI tag resolution; y repeats the previous scrambled bit (0 at the first index).
  always_comb begin
    scr_bit_c = in_bit ^ (gold_bit & ~byp_q);
    case (in_tag)
      TAG_X:   scr_bit_c = 1'b1;
      TAG_Y:   scr_bit_c = prev_q;
      default: scr_bit_c = in_bit ^ (gold_bit & ~byp_q);
    endcase
  end

  always_ff @(posedge CLK_PR_new or negedge RST_PR) begin
    if (!RST_PR) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      prev_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      gen_shift_q  <= 1'b0;
      gen_out_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PUSCH_SCR_BYPASS_EN
      byp_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept_c) begin
        out_bit_q   <= scr_bit_c;
        out_valid_q <= 1'b1;
        prev_q      <= scr_bit_c;
        cnt_q       <= cnt_q + LEN_W'(1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q  <= cw_len;
            cnt_q  <= '0;
            prev_q <= 1'b0;
            busy_q <= 1'b1;
`ifdef PUSCH_SCR_BYPASS_EN
            byp_q  <= bypass;
`endif
            if (cw_len == '0) begin
              state_q <= S_DRAIN;
`ifdef PUSCH_SCR_BYPASS_EN
            end else if (bypass) begin
              state_q <= S_RUN;
`endif
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          state_q     <= S_WARM;
          gen_shift_q <= 1'b1;
        end
        S_WARM: begin
          if (gold_valid) begin
            state_q      <= S_RUN;
            gen_shift_q  <= 1'b0;
            gen_out_en_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept_c && last_c) begin
            state_q      <= S_DRAIN;
            gen_out_en_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!out_valid_q || out_ready) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          gen_shift_q  <= 1'b0;
          gen_out_en_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign gen_shift  = gen_shift_q;
  assign gen_out_en = gen_out_en_q;
  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pusch_scr_core.sv
// Directed bench for pusch_scr_core with a small Gold-sequence source and output scoreboard.
module tb_pusch_scr_core;

  localparam int unsigned LEN_W = 17;

  logic             CLK_PR_new;
  logic             RST_PR;
  logic             start;
  logic [LEN_W-1:0] cw_len;
`ifdef PUSCH_SCR_BYPASS_EN
  logic             bypass;
`endif
  logic             gold_valid;
  logic             gold_bit;
  logic             gen_shift;
  logic             gen_out_en;
  logic             gen_adv;
  logic             in_valid;
  logic             in_bit;
  logic [1:0]       in_tag;
  logic             in_ready;
  logic             out_valid;
  logic             out_bit;
  logic             out_ready;
  logic             busy;
  logic             done;

  pusch_scr_core #(.LEN_W(LEN_W)) dut (
    .CLK_PR_new (CLK_PR_new),
    .RST_PR     (RST_PR),
    .start      (start),
    .cw_len     (cw_len),
`ifdef PUSCH_SCR_BYPASS_EN
    .bypass     (bypass),
`endif
    .gold_valid (gold_valid),
    .gold_bit   (gold_bit),
    .gen_shift  (gen_shift),
    .gen_out_en (gen_out_en),
    .gen_adv    (gen_adv),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_tag     (in_tag),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  initial CLK_PR_new = 1'b0;
  always #5 CLK_PR_new = ~CLK_PR_new;

  int n_chk  = 0;
  int n_pass = 0;

  // Gold source: index 0 of gold_vec is c(0) of the current codeword.
  logic [7:0] gold_vec = 8'h00;
  int         gpos = 0;
  int         gold_base = 0;
  assign gold_bit = gold_vec[3'(gpos - gold_base)];
  always @(posedge CLK_PR_new) if (gen_adv) gpos <= gpos + 1;

  int   cyc = 0;
  int   adv_cnt = 0, shift_cnt = 0, oen_cnt = 0, done_cnt = 0;
  int   last_hs_cyc = 0, last_done_cyc = 0;
  logic out_q[$];

  always @(posedge CLK_PR_new) cyc <= cyc + 1;

  always @(negedge CLK_PR_new) begin
    if (gen_adv)    adv_cnt++;
    if (gen_shift)  shift_cnt++;
    if (gen_out_en) oen_cnt++;
    if (out_valid && out_ready) begin
      out_q.push_back(out_bit);
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] outs(input int base, input int n);
    logic [7:0] v = '0;
    for (int k = 0; k < n; k++)
      v = {v[6:0], (base + k < out_q.size()) ? out_q[base + k] : 1'bx};
    return v;
  endfunction

  task automatic send_bit(input logic b, input logic [1:0] tag, output int waits);
    bit ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_tag   = tag;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK_PR_new);
      if (in_ready) begin
        ok = 1'b1;
        @(posedge CLK_PR_new);
        #1;
      end else begin
        waits++;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int n);
    bit seen = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK_PR_new);
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    @(posedge CLK_PR_new);
    #1;
  endtask

  task automatic start_cw(input logic [LEN_W-1:0] len);
    start  = 1'b1;
    cw_len = len;
    @(posedge CLK_PR_new); #1;
    start = 1'b0;
    @(posedge CLK_PR_new); #1;
    repeat (2) @(posedge CLK_PR_new);
    #1;
    gold_valid = 1'b1;
    @(posedge CLK_PR_new); #1;
    gold_valid = 1'b0;
  endtask

  initial begin
    int b, a0, s0, o0, d0, w, wsum, n;
    RST_PR = 1'b0; start = 1'b0; cw_len = '0; gold_valid = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; in_tag = 2'b00; out_ready = 1'b1;
`ifdef PUSCH_SCR_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (3) @(posedge CLK_PR_new);
    #1;
    chk("reset_outs", {gen_shift, gen_out_en, gen_adv, in_ready, out_valid, out_bit, busy, done}, 8'h00);
    RST_PR = 1'b1;
    @(posedge CLK_PR_new); #1;

    // Plain data codeword with explicit phase checks.
    gold_base = gpos; gold_vec = 8'b0000_0011; b = out_q.size(); a0 = adv_cnt; s0 = shift_cnt;
    start = 1'b1; cw_len = 17'd4;
    @(posedge CLK_PR_new); #1;
    start = 1'b0; cw_len = 17'h1FFFF;
    chk("t1_load", {busy, gen_shift, gen_out_en}, 3'b100);
    @(posedge CLK_PR_new); #1;
    chk("t1_warm", {gen_shift, gen_out_en}, 2'b10);
    repeat (3) @(posedge CLK_PR_new);
    #1;
    chk("t1_warm_hold", {gen_shift, gen_out_en, in_ready}, 3'b100);
    gold_valid = 1'b1;
    @(posedge CLK_PR_new); #1;
    gold_valid = 1'b0;
    chk("t1_run", {gen_shift, gen_out_en}, 2'b01);
    chk("t1_shift_cycles", shift_cnt - s0, 32'd4);
    send_bit(1'b1, 2'b00, w); send_bit(1'b0, 2'b00, w);
    send_bit(1'b1, 2'b00, w); send_bit(1'b1, 2'b00, w);
    in_valid = 1'b0;
    wait_done(n);
    chk("t1_out", outs(b, 4), 8'b0000_0111);
    chk("t1_adv", adv_cnt - a0, 32'd4);
    chk("t1_done_lat", last_done_cyc - last_hs_cyc, 32'd1);
    chk("t1_idle", {busy, done, gen_out_en}, 3'b000);

    // Placeholders: data, x, y.
    gold_base = gpos; gold_vec = 8'b0000_0110; b = out_q.size(); a0 = adv_cnt;
    start_cw(17'd3);
    send_bit(1'b1, 2'b00, w); send_bit(1'b0, 2'b01, w); send_bit(1'b0, 2'b10, w);
    in_valid = 1'b0;
    wait_done(n);
    chk("t2_out", outs(b, 3), 8'b0000_0111);
    chk("t2_adv", adv_cnt - a0, 32'd3);

    // First bit y resolves to 0; tag 11 scrambles as data.
    gold_base = gpos; gold_vec = 8'hFF; b = out_q.size(); a0 = adv_cnt;
    start_cw(17'd3);
    send_bit(1'b1, 2'b10, w); send_bit(1'b0, 2'b01, w); send_bit(1'b1, 2'b11, w);
    in_valid = 1'b0;
    wait_done(n);
    chk("t3_out", outs(b, 3), 8'b0000_0010);
    chk("t3_adv", adv_cnt - a0, 32'd3);

    // Backpressure: stall for 5 cycles, then full throughput.
    gold_base = gpos; gold_vec = 8'b0000_0101; b = out_q.size(); a0 = adv_cnt;
    start_cw(17'd4);
    out_ready = 1'b0;
    send_bit(1'b1, 2'b00, w);
    in_valid = 1'b1; in_bit = 1'b1; in_tag = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_PR_new);
      chk("t4_stall", {in_ready, gen_adv, out_valid, out_bit}, 4'b0010);
    end
    @(posedge CLK_PR_new); #1;
    out_ready = 1'b1;
    wsum = 0;
    send_bit(1'b1, 2'b00, w); wsum += w;
    send_bit(1'b0, 2'b00, w); wsum += w;
    send_bit(1'b0, 2'b00, w); wsum += w;
    in_valid = 1'b0;
    chk("t4_throughput_waits", wsum, 32'd0);
    wait_done(n);
    chk("t4_out", outs(b, 4), 8'b0000_0110);
    chk("t4_adv", adv_cnt - a0, 32'd4);

    // Zero-length codeword.
    a0 = adv_cnt; s0 = shift_cnt; d0 = done_cnt;
    start = 1'b1; cw_len = '0;
    @(posedge CLK_PR_new); #1;
    start = 1'b0;
    wait_done(n);
    chk("t5_done_within2", (n <= 2) ? 32'd1 : 32'd0, 32'd1);
    chk("t5_no_gen", {adv_cnt - a0, shift_cnt - s0}, 32'd0);
    chk("t5_done_once", done_cnt - d0, 32'd1);
    chk("t5_busy", busy, 32'd0);

    // Reset mid-codeword, then a fresh codeword.
    gold_base = gpos; gold_vec = 8'h00; d0 = done_cnt;
    start_cw(17'd8);
    send_bit(1'b1, 2'b00, w); send_bit(1'b0, 2'b00, w);
    in_valid = 1'b1;
    RST_PR = 1'b0;
    #1;
    chk("t6_reset_outs", {gen_shift, gen_out_en, gen_adv, in_ready, out_valid, out_bit, busy, done}, 8'h00);
    in_valid = 1'b0;
    repeat (2) @(posedge CLK_PR_new);
    #1;
    RST_PR = 1'b1;
    repeat (2) @(posedge CLK_PR_new);
    #1;
    chk("t6_no_done", done_cnt - d0, 32'd0);
    gold_base = gpos; gold_vec = 8'b0000_0010; b = out_q.size();
    start_cw(17'd2);
    send_bit(1'b1, 2'b00, w); send_bit(1'b0, 2'b00, w);
    in_valid = 1'b0;
    wait_done(n);
    chk("t6_out", outs(b, 2), 8'b0000_0011);
    chk("t6_done", done_cnt - d0, 32'd1);

`ifdef PUSCH_SCR_BYPASS_EN
    // Bypass: data passes unscrambled, generator idle.
    gold_base = gpos; gold_vec = 8'hFF; b = out_q.size();
    a0 = adv_cnt; s0 = shift_cnt; o0 = oen_cnt;
    bypass = 1'b1; start = 1'b1; cw_len = 17'd2;
    @(posedge CLK_PR_new); #1;
    start = 1'b0; bypass = 1'b0;
    send_bit(1'b1, 2'b00, w); send_bit(1'b0, 2'b00, w);
    in_valid = 1'b0;
    wait_done(n);
    chk("t7_out", outs(b, 2), 8'b0000_0010);
    chk("t7_no_gen", {adv_cnt - a0, shift_cnt - s0, oen_cnt - o0}, 32'd0);
`else
    o0 = oen_cnt;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
